// File: rtl/bit_serial_seq_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bit_serial_seq_if : start/opcode request and datapath control bus  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface bit_serial_seq_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH);

  logic          start;
  logic [3:0]    opcode;
  logic          busy;
  logic          le;
  logic          se;
  logic          ae;
  logic [2:0]    alu_op;
  logic          cin_load;
  logic          cin_val;
  logic [CW-1:0] bit_idx;
  logic          wb;
  logic          out_en;
  logic          done;
  logic          illegal;
  logic          overrun;

  modport master (
    output start, opcode,
    input  busy, le, se, ae, alu_op, cin_load, cin_val, bit_idx,
           wb, out_en, done, illegal, overrun
  );

  modport slave (
    input  start, opcode,
    output busy, le, se, ae, alu_op, cin_load, cin_val, bit_idx,
           wb, out_en, done, illegal, overrun
  );
endinterface
`default_nettype wire

// File: rtl/bit_serial_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bit_serial_seq : control sequencer for a bit-serial ALU datapath   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module bit_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  bit_serial_seq_if.slave  bus
);
  localparam int              CW     = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST   = CW'(WIDTH - 1);
  localparam logic [3:0]      OP_NOP = 4'd0;
  localparam logic [3:0]      OP_SUB = 4'd2;
  localparam logic [3:0]      OP_LDI = 4'd6;
  localparam logic [3:0]      OP_OUT = 4'd7;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t        state_q;
  logic [3:0]    op_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    alu_op_q;
  logic          busy_q, le_q, se_q, ae_q, cin_load_q, cin_val_q;
  logic          wb_q, out_en_q, done_q, illegal_q, overrun_q;

  logic          opc_legal;
  logic          opc_short;
  logic [2:0]    opc_alu;
  logic          op_acc;

  assign opc_legal = ~bus.opcode[3];
  assign opc_short = (bus.opcode == OP_NOP) || (bus.opcode == OP_OUT);
  // NOP and OUT both drive ALU function 0; arithmetic/logic ops map 1:1
  assign opc_alu   = ((bus.opcode != OP_NOP) && (bus.opcode <= OP_LDI)) ? bus.opcode[2:0] : 3'd0;
  assign op_acc    = (op_q != OP_NOP) && (op_q <= OP_LDI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= '0;
      cnt_q      <= '0;
      alu_op_q   <= '0;
      busy_q     <= 1'b0;
      le_q       <= 1'b0;
      se_q       <= 1'b0;
      ae_q       <= 1'b0;
      cin_load_q <= 1'b0;
      cin_val_q  <= 1'b0;
      wb_q       <= 1'b0;
      out_en_q   <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      le_q       <= 1'b0;
      se_q       <= 1'b0;
      ae_q       <= 1'b0;
      cin_load_q <= 1'b0;
      cin_val_q  <= 1'b0;
      wb_q       <= 1'b0;
      out_en_q   <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      overrun_q  <= bus.start && (state_q != IDLE);

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (opc_legal) begin
              op_q     <= bus.opcode;
              alu_op_q <= opc_alu;
              busy_q   <= 1'b1;
              if (opc_short) begin
                state_q  <= DONE;
                done_q   <= 1'b1;
                out_en_q <= (bus.opcode == OP_OUT);
              end else begin
                state_q    <= LOAD;
                le_q       <= 1'b1;
                cin_load_q <= 1'b1;
                cin_val_q  <= (bus.opcode == OP_SUB);
              end
            end else begin
              illegal_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          state_q <= SHIFT;
          cnt_q   <= '0;
          se_q    <= 1'b1;
          ae_q    <= op_acc;
        end
        SHIFT: begin
          // Last bit: leave with the counter cleared so no extra shift slips in
          if (cnt_q == LAST) begin
            state_q <= DONE;
            cnt_q   <= '0;
            done_q  <= 1'b1;
            wb_q    <= op_acc;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            se_q  <= 1'b1;
            ae_q  <= op_acc;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.le       = le_q;
  assign bus.se       = se_q;
  assign bus.ae       = ae_q;
  assign bus.alu_op   = alu_op_q;
  assign bus.cin_load = cin_load_q;
  assign bus.cin_val  = cin_val_q;
  assign bus.bit_idx  = cnt_q;
  assign bus.wb       = wb_q;
  assign bus.out_en   = out_en_q;
  assign bus.done     = done_q;
  assign bus.illegal  = illegal_q;
  assign bus.overrun  = overrun_q;
endmodule
`default_nettype wire

// File: tb/tb_bit_serial_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_bit_serial_seq : opcode table, timeline sequences, random model |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_bit_serial_seq;
  localparam int   W    = 8;
  localparam int   RCYC = 400;
  localparam int   NEXP = RCYC + W + 4;
  localparam logic H    = 1'b1;
  localparam logic L    = 1'b0;

  typedef struct packed {
    logic       busy, le, se, ae;
    logic [2:0] alu;
    logic       cl, cv;
    logic [2:0] idx;
    logic       wb, oe, dn, il, ov;
  } obs_t;

  typedef struct packed {
    logic [3:0] op;
    obs_t       exp;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  bit_serial_seq_if #(.WIDTH(W)) bus();
  bit_serial_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  obs_t obs;
  assign obs = {bus.busy, bus.le, bus.se, bus.ae, bus.alu_op, bus.cin_load, bus.cin_val,
                bus.bit_idx, bus.wb, bus.out_en, bus.done, bus.illegal, bus.overrun};

  function automatic obs_t mk(logic busy, logic le, logic se, logic ae, logic [2:0] alu,
                              logic cl, logic cv, logic [2:0] idx, logic wb, logic oe,
                              logic dn, logic il, logic ov);
    return {busy, le, se, ae, alu, cl, cv, idx, wb, oe, dn, il, ov};
  endfunction

  function automatic obs_t idle_obs(logic [2:0] alu);
    return mk(L, L, L, L, alu, L, L, 3'd0, L, L, L, L, L);
  endfunction

  task automatic check(string name, obs_t exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %05h required %05h", name, obs, exp);
    end
  endtask

  // Drive a request for the current cycle, advance to the next cycle's sample point
  task automatic tick(logic st, logic [3:0] op);
    bus.start  = st;
    bus.opcode = op;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    vec_t       tbl [18];
    obs_t       exp_q [NEXP];
    int         free_at;
    int         n;
    logic       st;
    logic [3:0] op;
    logic [2:0] a;

    bus.start  = 1'b0;
    bus.opcode = 4'd0;

    tbl[0]  = {4'd0,  mk(H, L, L, L, 3'd0, L, L, 3'd0, L, L, H, L, L)};
    tbl[1]  = {4'd1,  mk(H, H, L, L, 3'd1, H, L, 3'd0, L, L, L, L, L)};
    tbl[2]  = {4'd2,  mk(H, H, L, L, 3'd2, H, H, 3'd0, L, L, L, L, L)};
    tbl[3]  = {4'd3,  mk(H, H, L, L, 3'd3, H, L, 3'd0, L, L, L, L, L)};
    tbl[4]  = {4'd4,  mk(H, H, L, L, 3'd4, H, L, 3'd0, L, L, L, L, L)};
    tbl[5]  = {4'd5,  mk(H, H, L, L, 3'd5, H, L, 3'd0, L, L, L, L, L)};
    tbl[6]  = {4'd6,  mk(H, H, L, L, 3'd6, H, L, 3'd0, L, L, L, L, L)};
    tbl[7]  = {4'd7,  mk(H, L, L, L, 3'd0, L, L, 3'd0, L, H, H, L, L)};
    for (int i = 8; i < 16; i++)
      tbl[i] = {4'(i), mk(L, L, L, L, 3'd0, L, L, 3'd0, L, L, L, H, L)};
    tbl[16] = {4'd5,  mk(H, H, L, L, 3'd5, H, L, 3'd0, L, L, L, L, L)};
    tbl[17] = {4'd12, mk(L, L, L, L, 3'd5, L, L, 3'd0, L, L, L, H, L)};

    @(negedge clk);
    check("reset", idle_obs(3'd0));
    rst_n = 1'b1;
    @(negedge clk);

    // First-cycle response for every opcode
    for (int i = 0; i < 18; i++) begin
      tick(1'b1, tbl[i].op);
      check($sformatf("tbl%0d_op%0d", i, tbl[i].op), tbl[i].exp);
      n = 0;
      while (bus.busy && n < W + 4) begin
        tick(1'b0, 4'd0);
        n++;
      end
      if (bus.busy) begin
        vectors++;
        miscompares++;
        $display("FAIL tbl%0d_timeout: busy=%0b required 0", i, bus.busy);
      end
    end

    // ADD full timeline
    tick(1'b1, 4'd1);
    check("add_load", mk(H, H, L, L, 3'd1, H, L, 3'd0, L, L, L, L, L));
    for (int k = 0; k < W; k++) begin
      tick(1'b0, 4'd0);
      check($sformatf("add_shift%0d", k), mk(H, L, H, H, 3'd1, L, L, 3'(k), L, L, L, L, L));
    end
    tick(1'b0, 4'd0);
    check("add_done", mk(H, L, L, L, 3'd1, L, L, 3'd0, H, L, H, L, L));
    tick(1'b0, 4'd0);
    check("add_idle", idle_obs(3'd1));

    // SUB with an overrun start at N+4 and another during DONE
    tick(1'b1, 4'd2);
    check("sub_load", mk(H, H, L, L, 3'd2, H, H, 3'd0, L, L, L, L, L));
    for (int t = 2; t <= 9; t++) begin
      tick(t == 5, 4'd5);
      check($sformatf("sub_ovr_n%0d", t),
            mk(H, L, H, H, 3'd2, L, L, 3'(t - 2), L, L, L, L, t == 5));
    end
    tick(1'b0, 4'd0);
    check("sub_done", mk(H, L, L, L, 3'd2, L, L, 3'd0, H, L, H, L, L));
    tick(1'b1, 4'd1);
    check("start_in_done", mk(L, L, L, L, 3'd2, L, L, 3'd0, L, L, L, L, H));
    tick(1'b0, 4'd0);
    check("after_done_ovr", idle_obs(3'd2));

    // Asynchronous reset in the middle of SHIFT
    tick(1'b1, 4'd3);
    for (int t = 2; t <= 5; t++) tick(1'b0, 4'd0);
    rst_n = 1'b0;
    #1;
    check("rst_async", idle_obs(3'd0));
    tick(1'b0, 4'd0);
    check("rst_hold0", idle_obs(3'd0));
    tick(1'b0, 4'd0);
    check("rst_hold1", idle_obs(3'd0));
    rst_n = 1'b1;
    tick(1'b1, 4'd6);
    check("post_rst_load", mk(H, H, L, L, 3'd6, H, L, 3'd0, L, L, L, L, L));
    for (int k = 0; k < W; k++) tick(1'b0, 4'd0);
    tick(1'b0, 4'd0);
    check("post_rst_done", mk(H, L, L, L, 3'd6, L, L, 3'd0, H, L, H, L, L));
    tick(1'b0, 4'd0);
    check("post_rst_idle", idle_obs(3'd6));

    // Random requests against a schedule-based timeline model
    for (int c = 0; c < NEXP; c++) exp_q[c] = idle_obs(3'd6);
    free_at = 0;
    for (int c = 0; c < NEXP - 1; c++) begin
      check($sformatf("rand_c%0d", c), exp_q[c]);
      st = 1'b0;
      op = 4'd0;
      if (c < RCYC) begin
        st = ($urandom_range(0, 2) == 0);
        op = 4'($urandom_range(0, 11));
      end
      if (st) begin
        if (c < free_at) begin
          exp_q[c + 1].ov = 1'b1;
        end else if (op >= 4'd8) begin
          exp_q[c + 1].il = 1'b1;
        end else begin
          a = (op == 4'd7) ? 3'd0 : op[2:0];
          for (int t = c + 1; t < NEXP; t++) exp_q[t].alu = a;
          exp_q[c + 1].busy = 1'b1;
          if (op == 4'd0 || op == 4'd7) begin
            exp_q[c + 1].dn = 1'b1;
            exp_q[c + 1].oe = (op == 4'd7);
            free_at = c + 2;
          end else begin
            exp_q[c + 1].le = 1'b1;
            exp_q[c + 1].cl = 1'b1;
            exp_q[c + 1].cv = (op == 4'd2);
            for (int k = 0; k < W; k++) begin
              exp_q[c + 2 + k].busy = 1'b1;
              exp_q[c + 2 + k].se   = 1'b1;
              exp_q[c + 2 + k].ae   = 1'b1;
              exp_q[c + 2 + k].idx  = 3'(k);
            end
            exp_q[c + W + 2].busy = 1'b1;
            exp_q[c + W + 2].dn   = 1'b1;
            exp_q[c + W + 2].wb   = 1'b1;
            free_at = c + W + 3;
          end
        end
      end
      tick(st, op);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
